// File: rtl/ivl_uvm_ovl_fire_pkg.sv
// ---------------------------------------------------------------------------
// ivl_uvm_ovl_fire_pkg
// Shared definitions for the OVL fire collector:
//   - bit positions inside one checker's 3-bit fire vector
//   - log_type encodings
//   - fire_rec_t, the record stored in the event FIFO
//   - id_width(), derives the checker-index width from the checker count
// fire_rec_t is sized for the largest supported configuration (16 checkers,
// 32-bit timestamps). The collector zero-extends into it and trims on the way out.
// ---------------------------------------------------------------------------
package ivl_uvm_ovl_fire_pkg;

    // Bit positions within one checker's fire vector
    localparam int FIRE_ASSERT = 0;
    localparam int FIRE_XCHECK = 1;
    localparam int FIRE_COVER  = 2;
    localparam int FIRE_BITS   = 3;

    // log_type encodings
    localparam logic LOG_TYPE_ASSERT = 1'b0;
    localparam logic LOG_TYPE_XCHECK = 1'b1;

    // Upper bounds for record fields
    localparam int REC_ID_W   = 4;
    localparam int REC_TIME_W = 32;

    typedef struct packed {
        logic [REC_ID_W-1:0]   id;
        logic                  typ;
        logic [REC_TIME_W-1:0] stamp;
    } fire_rec_t;

    // Checker-index width with a floor of one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ivl_uvm_ovl_fire_fifo.sv
// ---------------------------------------------------------------------------
// ivl_uvm_ovl_fire_fifo
// Synchronous show-ahead FIFO of fire_rec_t records.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   clear        : synchronous flush; wins over push and pop
//   push/push_rec: write request and data (accepted when not full, or when
//                  full and a pop happens in the same cycle)
//   pop          : remove head record (ignored when empty)
//   head_rec     : current head record, valid while empty is low
//   empty/full   : derived from read/write pointers carrying an extra wrap bit
// ---------------------------------------------------------------------------
module ivl_uvm_ovl_fire_fifo
    import ivl_uvm_ovl_fire_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      clear,
    input  logic      push,
    input  fire_rec_t push_rec,
    input  logic      pop,
    output fire_rec_t head_rec,
    output logic      empty,
    output logic      full
);

    localparam int AW = $clog2(DEPTH);

    fire_rec_t    mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push;
    logic         do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot this cycle, so a push at full is legal alongside it
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_rec;
    end

    assign head_rec = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ivl_uvm_ovl_fire_collector.sv
// ---------------------------------------------------------------------------
// ivl_uvm_ovl_fire_collector
// Gathers OVL checker fire vectors, counts failures, keeps sticky status and
// queues one {id, type, timestamp} record per failure event.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   enable              gates fire qualification (FIFO drain unaffected)
//   clear               synchronous flush of counters, pending, FIFO, flags
//   fire_in             checker k at [3k+2:3k] = {cover, xcheck, assert}
//   log_valid/ready     show-ahead record port; pop on valid && ready
//   log_id/type/time    head record fields
//   fail_cnt            saturating count of failure events
//   any_fail, first_id  sticky first-failure status
//   ovfl                sticky: an event was dropped
// Build option: define OVL_FIRE_XCHECK_EN to treat xcheck bits as failures
// (log_type=1). Without it xcheck bits are ignored and log_type is 0.
// ---------------------------------------------------------------------------
module ivl_uvm_ovl_fire_collector
    import ivl_uvm_ovl_fire_pkg::*;
#(
    parameter int NUM_CHK   = 4,
    parameter int CNT_W     = 16,
    parameter int LOG_DEPTH = 8,
    localparam int IDW      = id_width(NUM_CHK)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         clear,
    input  logic [FIRE_BITS*NUM_CHK-1:0] fire_in,
    output logic                         log_valid,
    input  logic                         log_ready,
    output logic [IDW-1:0]               log_id,
    output logic                         log_type,
    output logic [CNT_W-1:0]             log_time,
    output logic [CNT_W-1:0]             fail_cnt,
    output logic                         any_fail,
    output logic [IDW-1:0]               first_id,
    output logic                         ovfl
);

    localparam int SUM_W = CNT_W + 5;   // room for adding up to 16 events

    logic [CNT_W-1:0]   ts_cnt_q, ts_cnt_d;
    logic [NUM_CHK-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]   pts_q [NUM_CHK];
    logic [CNT_W-1:0]   pts_d [NUM_CHK];
`ifdef OVL_FIRE_XCHECK_EN
    logic [NUM_CHK-1:0] ptyp_q, ptyp_d;
`endif
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic               any_fail_q, any_fail_d;
    logic [IDW-1:0]     first_id_q, first_id_d;
    logic               ovfl_q, ovfl_d;

    logic [NUM_CHK-1:0] fail_vec;
    logic [NUM_CHK-1:0] fail_typ;
    logic [NUM_CHK-1:0] cover_bits;
    logic [NUM_CHK-1:0] grant_vec;
    logic [NUM_CHK-1:0] drained;
    logic [IDW-1:0]     grant_idx;
    logic               grant_any;
    logic [IDW-1:0]     low_fail_idx;
    logic [4:0]         fail_pop;
    logic [SUM_W-1:0]   fail_sum;

    fire_rec_t          push_rec;
    fire_rec_t          head_rec;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic               fifo_full;

    // Per-checker qualification
    for (genvar gi = 0; gi < NUM_CHK; gi++) begin : g_qual
        assign cover_bits[gi] = fire_in[FIRE_BITS*gi+FIRE_COVER];
`ifdef OVL_FIRE_XCHECK_EN
        assign fail_vec[gi] = enable & (fire_in[FIRE_BITS*gi+FIRE_ASSERT] |
                                        fire_in[FIRE_BITS*gi+FIRE_XCHECK]);
        // assert wins when both fire in the same cycle
        assign fail_typ[gi] = fire_in[FIRE_BITS*gi+FIRE_ASSERT] ?
                              LOG_TYPE_ASSERT : LOG_TYPE_XCHECK;
`else
        assign fail_vec[gi] = enable & fire_in[FIRE_BITS*gi+FIRE_ASSERT];
        assign fail_typ[gi] = fire_in[FIRE_BITS*gi+FIRE_XCHECK];
`endif
    end

    // Fixed-priority arbiter over pending entries (lowest index wins) and
    // lowest-index search over this cycle's failures
    always_comb begin
        grant_vec    = '0;
        grant_idx    = '0;
        grant_any    = 1'b0;
        low_fail_idx = '0;
        fail_pop     = '0;
        for (int k = NUM_CHK - 1; k >= 0; k--) begin
            if (pend_q[k]) begin
                grant_vec    = '0;
                grant_vec[k] = 1'b1;
                grant_idx    = IDW'(k);
                grant_any    = 1'b1;
            end
            if (fail_vec[k]) low_fail_idx = IDW'(k);
        end
        for (int k = 0; k < NUM_CHK; k++) begin
            fail_pop = fail_pop + {4'b0, fail_vec[k]};
        end
    end

    assign fifo_pop  = log_valid && log_ready;
    assign fifo_push = grant_any && (!fifo_full || fifo_pop);
    assign drained   = fifo_push ? grant_vec : '0;

    always_comb begin
        push_rec       = '0;
        push_rec.id    = REC_ID_W'(grant_idx);
        push_rec.stamp = REC_TIME_W'(pts_q[grant_idx]);
`ifdef OVL_FIRE_XCHECK_EN
        push_rec.typ   = ptyp_q[grant_idx];
`else
        push_rec.typ   = LOG_TYPE_ASSERT;
`endif
    end

    // Capture, counting and sticky flags
    always_comb begin
        ts_cnt_d   = ts_cnt_q + 1'b1;
        pend_d     = pend_q & ~drained;
        pts_d      = pts_q;
`ifdef OVL_FIRE_XCHECK_EN
        ptyp_d     = ptyp_q;
`endif
        ovfl_d     = ovfl_q;
        any_fail_d = any_fail_q;
        first_id_d = first_id_q;

        for (int k = 0; k < NUM_CHK; k++) begin
            if (fail_vec[k]) begin
                // A slot being drained this cycle can take the new event
                if (pend_q[k] && !drained[k]) begin
                    ovfl_d = 1'b1;
                end else begin
                    pend_d[k] = 1'b1;
                    pts_d[k]  = ts_cnt_q;
`ifdef OVL_FIRE_XCHECK_EN
                    ptyp_d[k] = fail_typ[k];
`endif
                end
            end
        end

        fail_sum = SUM_W'(fail_cnt_q) + SUM_W'(fail_pop);
        if (fail_sum[SUM_W-1:CNT_W] != '0) fail_cnt_d = '1;
        else                                fail_cnt_d = fail_sum[CNT_W-1:0];

        if (!any_fail_q && (fail_vec != '0)) begin
            any_fail_d = 1'b1;
            first_id_d = low_fail_idx;
        end

        if (clear) begin
            ts_cnt_d   = '0;
            pend_d     = '0;
            for (int k = 0; k < NUM_CHK; k++) pts_d[k] = '0;
`ifdef OVL_FIRE_XCHECK_EN
            ptyp_d     = '0;
`endif
            ovfl_d     = 1'b0;
            any_fail_d = 1'b0;
            first_id_d = '0;
            fail_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_cnt_q   <= '0;
            pend_q     <= '0;
            for (int k = 0; k < NUM_CHK; k++) pts_q[k] <= '0;
`ifdef OVL_FIRE_XCHECK_EN
            ptyp_q     <= '0;
`endif
            fail_cnt_q <= '0;
            any_fail_q <= 1'b0;
            first_id_q <= '0;
            ovfl_q     <= 1'b0;
        end else begin
            ts_cnt_q   <= ts_cnt_d;
            pend_q     <= pend_d;
            pts_q      <= pts_d;
`ifdef OVL_FIRE_XCHECK_EN
            ptyp_q     <= ptyp_d;
`endif
            fail_cnt_q <= fail_cnt_d;
            any_fail_q <= any_fail_d;
            first_id_q <= first_id_d;
            ovfl_q     <= ovfl_d;
        end
    end

    ivl_uvm_ovl_fire_fifo #(
        .DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .push     (fifo_push),
        .push_rec (push_rec),
        .pop      (fifo_pop),
        .head_rec (head_rec),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign log_valid = !fifo_empty;
    assign log_id    = head_rec.id[IDW-1:0];
    assign log_time  = head_rec.stamp[CNT_W-1:0];
`ifdef OVL_FIRE_XCHECK_EN
    assign log_type  = head_rec.typ;
`else
    assign log_type  = LOG_TYPE_ASSERT;
`endif
    assign fail_cnt  = fail_cnt_q;
    assign any_fail  = any_fail_q;
    assign first_id  = first_id_q;
    assign ovfl      = ovfl_q;

    // Cover bits, untouched type/upper record bits are intentionally dropped
    logic unused_bits;
    assign unused_bits = ^{cover_bits, fail_typ, head_rec};

endmodule

// File: tb/tb_ivl_uvm_ovl_fire_collector.sv
module tb_ivl_uvm_ovl_fire_collector;

    localparam int NUM_CHK = 4;
    localparam int CNT_W   = 5;
    localparam int DEPTH   = 8;
    localparam int IDW     = 2;
    localparam int FW      = 3 * NUM_CHK;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b1;
    logic             clear = 1'b0;
    logic [FW-1:0]    fire_in = '0;
    logic             log_valid;
    logic             log_ready = 1'b1;
    logic [IDW-1:0]   log_id;
    logic             log_type;
    logic [CNT_W-1:0] log_time;
    logic [CNT_W-1:0] fail_cnt;
    logic             any_fail;
    logic [IDW-1:0]   first_id;
    logic             ovfl;

    ivl_uvm_ovl_fire_collector #(
        .NUM_CHK   (NUM_CHK),
        .CNT_W     (CNT_W),
        .LOG_DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .fire_in   (fire_in),
        .log_valid (log_valid),
        .log_ready (log_ready),
        .log_id    (log_id),
        .log_type  (log_type),
        .log_time  (log_time),
        .fail_cnt  (fail_cnt),
        .any_fail  (any_fail),
        .first_id  (first_id),
        .ovfl      (ovfl)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int id; int typ; int t; } rec_t;
    rec_t m_q[$];
    bit   m_pend [NUM_CHK];
    int   m_pt   [NUM_CHK];
    int   m_ptyp [NUM_CHK];
    int   m_ts, m_cnt, m_first;
    bit   m_any, m_ovfl;

    task automatic m_reset();
        m_q.delete();
        for (int k = 0; k < NUM_CHK; k++) begin
            m_pend[k] = 0; m_pt[k] = 0; m_ptyp[k] = 0;
        end
        m_ts = 0; m_cnt = 0; m_first = 0; m_any = 0; m_ovfl = 0;
    endtask

    task automatic m_step();
        bit   popped, pushed, fails[NUM_CHK];
        int   ftyp[NUM_CHK];
        int   g, nfail;
        rec_t r;
        popped = (m_q.size() > 0) && log_ready;
        if (clear) begin
            m_reset();
            return;
        end
        nfail = 0;
        for (int k = 0; k < NUM_CHK; k++) begin
`ifdef OVL_FIRE_XCHECK_EN
            fails[k] = enable && (fire_in[3*k] || fire_in[3*k+1]);
            ftyp[k]  = fire_in[3*k] ? 0 : 1;
`else
            fails[k] = enable && fire_in[3*k];
            ftyp[k]  = 0;
`endif
            if (fails[k]) nfail++;
        end
        g = -1;
        for (int k = 0; k < NUM_CHK; k++) if (m_pend[k] && g < 0) g = k;
        pushed = (g >= 0) && (m_q.size() < DEPTH || popped);
        if (pushed) begin
            r.id = g; r.typ = m_ptyp[g]; r.t = m_pt[g];
            m_pend[g] = 0;
        end
        for (int k = 0; k < NUM_CHK; k++) begin
            if (fails[k]) begin
                if (m_pend[k]) m_ovfl = 1;
                else begin m_pend[k] = 1; m_pt[k] = m_ts; m_ptyp[k] = ftyp[k]; end
            end
        end
        if (popped) void'(m_q.pop_front());
        if (pushed) m_q.push_back(r);
        m_cnt = (m_cnt + nfail > CNT_MAX) ? CNT_MAX : m_cnt + nfail;
        if (!m_any && nfail > 0) begin
            m_any = 1;
            for (int k = NUM_CHK - 1; k >= 0; k--) if (fails[k]) m_first = k;
        end
        m_ts = (m_ts + 1) % (CNT_MAX + 1);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) m_reset();
            else       m_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("log_valid", log_valid, m_q.size() > 0);
                if (m_q.size() > 0) begin
                    chk("log_id",   log_id,   m_q[0].id);
                    chk("log_type", log_type, m_q[0].typ);
                    chk("log_time", log_time, m_q[0].t);
                end
                chk("fail_cnt", fail_cnt, m_cnt);
                chk("any_fail", any_fail, m_any);
                chk("ovfl",     ovfl,     m_ovfl);
                if (m_any) chk("first_id", first_id, m_first);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_ts(input int v);
        int n = 0;
        while (m_ts != v && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("wait_ts_bound", (m_ts == v), 1);
    endtask

    task automatic pulse_fire(input logic [FW-1:0] f);
        fire_in = f;
        @(negedge clock);
        fire_in = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset with idle fire
        wait_ts(5);
        chk("idle_valid", log_valid, 0);
        chk("idle_cnt",   fail_cnt, 0);
        chk("idle_any",   any_fail, 0);
        chk("idle_ovfl",  ovfl, 0);
        $display("txn reset_idle done");

        // Single failure: checker 2 at ts 5
        pulse_fire(12'h040);
        chk("single_cnt",   fail_cnt, 1);
        chk("single_any",   any_fail, 1);
        chk("single_first", first_id, 2);
        chk("single_nolat", log_valid, 0);
        @(negedge clock);
        chk("single_valid", log_valid, 1);
        chk("single_id",    log_id, 2);
        chk("single_type",  log_type, 0);
        chk("single_time",  log_time, 5);
        @(negedge clock);
        chk("single_popped", log_valid, 0);
        $display("txn single id=2 time=5");

        // Simultaneous failures at ts 20 after a clear
        do_clear();
        wait_ts(20);
        pulse_fire(12'h209);
        chk("simul_cnt",   fail_cnt, 3);
        chk("simul_first", first_id, 0);
        @(negedge clock);
        chk("simul_id0", log_id, 0);  chk("simul_t0", log_time, 20);
        @(negedge clock);
        chk("simul_id1", log_id, 1);  chk("simul_t1", log_time, 20);
        @(negedge clock);
        chk("simul_id3", log_id, 3);  chk("simul_t3", log_time, 20);
        @(negedge clock);
        chk("simul_empty", log_valid, 0);
        $display("txn simultaneous ids=0,1,3 time=20");

        // Back-pressure and overflow
        log_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pulse_fire(12'h001);
            if (i < 8) @(negedge clock);
        end
        chk("bp_valid", log_valid, 1);
        chk("bp_ovfl0", ovfl, 0);
        chk("bp_cnt9",  fail_cnt, 12);
        pulse_fire(12'h001);
        chk("bp_ovfl1", ovfl, 1);
        chk("bp_cnt10", fail_cnt, 13);
        log_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (log_valid) cnt++;
            @(negedge clock);
        end
        chk("bp_drained", cnt, 9);
        $display("txn backpressure drained=%0d", cnt);

        // Enable low then clear
        enable = 1'b0;
        fire_in = 12'h008;
        repeat (3) @(negedge clock);
        fire_in = '0;
        enable = 1'b1;
        @(negedge clock);
        chk("en_cnt",   fail_cnt, 13);
        chk("en_valid", log_valid, 0);
        do_clear();
        chk("clr_cnt",   fail_cnt, 0);
        chk("clr_any",   any_fail, 0);
        chk("clr_ovfl",  ovfl, 0);
        chk("clr_first", first_id, 0);
        chk("clr_valid", log_valid, 0);
        pulse_fire(12'h200);
        @(negedge clock);
        chk("clr_ts_valid", log_valid, 1);
        chk("clr_ts_id",    log_id, 3);
        chk("clr_ts_time",  log_time, 0);
        @(negedge clock);
        $display("txn enable_clear ts_restart=%0d", log_time);

        // xcheck, then assert+xcheck on the same checker
        do_clear();
        pulse_fire(12'h010);
        @(negedge clock);
`ifdef OVL_FIRE_XCHECK_EN
        chk("xc_valid", log_valid, 1);
        chk("xc_id",    log_id, 1);
        chk("xc_type",  log_type, 1);
        chk("xc_cnt",   fail_cnt, 1);
`else
        chk("xc_valid", log_valid, 0);
        chk("xc_cnt",   fail_cnt, 0);
`endif
        @(negedge clock);
        pulse_fire(12'h0c0);
        @(negedge clock);
        chk("both_valid", log_valid, 1);
        chk("both_id",    log_id, 2);
        chk("both_type",  log_type, 0);
`ifdef OVL_FIRE_XCHECK_EN
        chk("both_cnt",   fail_cnt, 2);
        chk("both_first", first_id, 1);
`else
        chk("both_cnt",   fail_cnt, 1);
        chk("both_first", first_id, 2);
`endif
        @(negedge clock);
        chk("both_single", log_valid, 0);
        $display("txn xcheck cnt=%0d", fail_cnt);

        // Saturation: all asserts for 8 cycles
        fire_in = 12'h249;
        repeat (8) @(negedge clock);
        fire_in = '0;
        repeat (8) @(negedge clock);
        chk("sat_cnt",  fail_cnt, CNT_MAX);
        chk("sat_ovfl", ovfl, 1);
        chk("sat_empty", log_valid, 0);
        $display("txn saturate cnt=%0d", fail_cnt);

        // Asynchronous reset mid-operation
        log_ready = 1'b0;
        pulse_fire(12'h009);
        repeat (2) @(negedge clock);
        chk("mid_pre_valid", log_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_valid", log_valid, 0);
        chk("mid_cnt",   fail_cnt, 0);
        chk("mid_any",   any_fail, 0);
        chk("mid_ovfl",  ovfl, 0);
        @(negedge clock);
        reset = 1'b0;
        log_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("post_valid", log_valid, 0);
        $display("txn midreset done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ivl_uvm_ovl_fire_collector.md
# ivl_uvm_ovl_fire_collector

Collects the `fire` outputs of up to NUM_CHK OVL checkers (e.g. `ovl_unchange`, `ovl_change`) in a test environment. It counts failures, latches sticky pass/fail status and first-failing checker ID, and queues per-event records `{checker id, fire type, timestamp}` for a testbench or UVM monitor to drain through a valid/ready port. It sits directly downstream of the checker instances, alongside the shared clock generator.

## Interface
- NUM_CHK, default 4, number of checkers monitored (1..16)
- CNT_W, default 16, width of the timestamp and failure counter
- LOG_DEPTH, default 8, event FIFO depth (power of 2, ≥2)
- IDW, derived, `$clog2(NUM_CHK)` with a minimum of 1

- clock  in  1  sampling clock, rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  when low, fire inputs are ignored; the FIFO can still be drained
- clear  in  1  synchronous; clears counters, pending, FIFO and sticky flags
- fire_in  in  3*NUM_CHK  OVL fire vectors; checker k occupies bits [3k+2:3k]: bit0 assert, bit1 xcheck, bit2 cover
- log_valid  out  1  head record available
- log_ready  in  1  pop head record when log_valid && log_ready
- log_id  out  IDW  checker index of head record
- log_type  out  1  0 = assert failure, 1 = xcheck
- log_time  out  CNT_W  cycle timestamp captured when the fire was sampled
- fail_cnt  out  CNT_W  total failure events, saturating
- any_fail  out  1  sticky; set by the first failure
- first_id  out  IDW  index of the first failing checker; valid when any_fail is high
- ovfl  out  1  sticky; an event was lost

## Operation
- **Reset values.** All outputs are 0, all pending bits are 0, FIFO is empty, timestamp counter is 0.
- **Timestamp.** Free-running CNT_W-bit counter; increments every cycle and wraps from all-ones to 0. Not gated by enable. Cleared by clear.
- **Event qualification.** Checker k fails in a cycle when enable is high and fire_in[3k] is high. xcheck behaviour is set by the macro in Configuration. Cover bits are always ignored.
- **Capture.** On a failing cycle, pend[k] is set and ts[k] is loaded with the current timestamp. If pend[k] is already set and not being drained this cycle, the new event is dropped and ovfl is set. If assert and xcheck both fire for the same checker in one cycle, only the assert event is logged.
- **Counting.** fail_cnt adds the popcount of failing checkers each cycle and saturates at all-ones.
- **First failure.** On the first failing cycle after reset or clear, any_fail is set and first_id takes the lowest failing index. Both then hold.
- **Drain arbiter.** Fixed priority, lowest index first. Each cycle, if any pend bit is set and the FIFO is not full, the highest-priority entry is written to the FIFO and its pend bit is cleared. A pend bit may be cleared and re-set in the same cycle.
- **FIFO full.** Pending entries hold; there is no loss until the same checker fires again.
- **Simultaneous push and pop.** Allowed at full and at empty.
- **clear.** Dominates capture, push and pop in the same cycle.
- **Reset mid-operation.** Asynchronous reset discards everything immediately.

## Timing
- Fire sampled at edge N: pend, ts, fail_cnt, any_fail and first_id update at N.
- FIFO write happens at edge N+1 at the earliest. log_valid rises after N+1, giving 2-edge latency from fire to record visible.
- The FIFO is show-ahead: log_id, log_type and log_time are stable while log_valid is high and log_ready is low.
- Throughput is one record per cycle. M simultaneous failures appear over M consecutive cycles.

## Configuration
- **OVL_FIRE_XCHECK_EN defined:**
  - fire_in[3k+1] is a failure with log_type=1.
  - It counts in fail_cnt and can set any_fail and first_id.
  - pend and ts carry one extra type bit.
- **OVL_FIRE_XCHECK_EN undefined:**
  - xcheck bits are ignored.
  - log_type is tied to 0.

## Structure
- **Package `ivl_uvm_ovl_fire_pkg`:**
  - fire bit index constants FIRE_ASSERT=0, FIRE_XCHECK=1, FIRE_COVER=2
  - log_type encodings
  - parameterised record struct `fire_rec_t` {id, type, time}
- **Sub-module `ivl_uvm_ovl_fire_fifo`:**
  - synchronous show-ahead FIFO of `fire_rec_t`
  - depth LOG_DEPTH
  - full/empty derived from pointers with an extra wrap bit
- **Top level:** timestamp counter, capture logic, pend/ts registers, arbiter, sticky flags.

## Test plan
- **Reset with idle fire.** Reset high, then low with fire_in=0 for 10 cycles → log_valid=0, fail_cnt=0, any_fail=0, ovfl=0.
- **Single failure.** Checker 2 fire[0] pulses for 1 cycle at timestamp 5, log_ready=1 → one record {id=2, type=0, time=5} visible 2 edges later; fail_cnt=1; any_fail=1; first_id=2.
- **Simultaneous failures.** Checkers 0, 1 and 3 fire in the same cycle at t=20 → fail_cnt += 3; records appear in id order 0, 1, 3 on consecutive cycles, all with time=20; first_id=0.
- **Back-pressure and overflow.** log_ready=0, checker 0 fires 9 times, one cycle apart, with LOG_DEPTH=8 → FIFO fills with 8 records; the 9th stays pending; ovfl=0. A 10th fire then sets ovfl=1. Raising log_ready drains 9 records.
- **Enable and clear.** enable=0 while checker 1 fires → no effect. Then clear=1 for 1 cycle → all counters, flags and FIFO are 0 and the timestamp restarts at 0.
- **xcheck.** Checker 1 fire[1] fires → with OVL_FIRE_XCHECK_EN defined, record {id=1, type=1} and fail_cnt=1; without the macro, no record and fail_cnt=0.
